// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative multiply/divide unit for the Execute stage. It holds the
// architectural HI/LO registers. Multiplies are shift-add, one bit per cycle.
// Divides are restoring division, one bit per cycle. Signed forms are handled
// by running on magnitudes, then applying a sign fix-up in a final cycle.
//
// Ports:
//   clk, rst     - clock (rising edge); asynchronous active-high reset
//   start        - ID/EX entry valid this cycle
//   aluop        - main-decoder op class; only 2'b10 (R-type) enables decode
//   funct        - R-type function field
//   a, b         - rs / rt operands
//   result       - combinational MFHI/MFLO read data, 0 otherwise
//   hi, lo       - architectural HI/LO registers
//   busy         - registered; an operation is in flight
//   stall        - combinational request to freeze IF/ID/EX
//   done         - registered one-cycle pulse after HI/LO written by an op
//   div_by_zero  - sticky; cleared when the next MULT/DIV is accepted
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg;
    // Multiply: {partial product high, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    // Divide by zero: preloaded with the final {hi, lo} pair.
    logic [2*WIDTH-1:0]   acc_reg;
    logic [WIDTH-1:0]     opnd_reg;       // multiplicand or divisor magnitude
    logic                 neg_q_reg;      // negate product / quotient
    logic                 neg_r_reg;      // negate remainder
    logic                 is_div_reg;
    logic                 dz_pend_reg;
    logic [WIDTH-1:0]     hi_reg, lo_reg;
    logic                 busy_reg, done_reg, dz_reg;

    // ---------------- decode ----------------
    logic dec_r;
    logic is_mult, is_multu, is_div, is_divu;
    logic is_mfhi, is_mflo, is_mthi, is_mtlo;
    logic is_op, is_any;

    always_comb begin
        dec_r    = start && (aluop == 2'b10);
        is_mult  = dec_r && (funct == F_MULT);
        is_multu = dec_r && (funct == F_MULTU);
        is_div   = dec_r && (funct == F_DIV);
        is_divu  = dec_r && (funct == F_DIVU);
        is_mfhi  = dec_r && (funct == F_MFHI);
        is_mflo  = dec_r && (funct == F_MFLO);
        is_mthi  = dec_r && (funct == F_MTHI);
        is_mtlo  = dec_r && (funct == F_MTLO);
        is_op    = is_mult || is_multu || is_div || is_divu;
        is_any   = is_op || is_mfhi || is_mflo || is_mthi || is_mtlo;
    end

    assign stall       = busy_reg && is_any;
    assign result      = is_mfhi ? hi_reg : (is_mflo ? lo_reg : '0);
    assign hi          = hi_reg;
    assign lo          = lo_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign div_by_zero = dz_reg;

    // ---------------- operand preparation ----------------
    logic             op_signed;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        op_signed = is_mult || is_div;
        a_mag     = (op_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_mag     = (op_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    end

    // ---------------- iteration datapath ----------------
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_acc_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   div_acc_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     fix_hi, fix_lo;
    logic                 last_iter;

    always_comb begin
        // Add the multiplicand into the upper half when the current
        // multiplier bit is set, then shift the whole accumulator right.
        mul_sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                     + (acc_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
        mul_acc_next = {mul_sum, acc_reg[WIDTH-1:1]};

        // Shift the next dividend bit into the remainder and trial-subtract;
        // keep the difference only when it did not go negative.
        div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
        div_trial = div_shift - {1'b0, opnd_reg};
        if (!div_trial[WIDTH]) begin
            div_acc_next = {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
        end else begin
            div_acc_next = {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
        end

        prod_fix = neg_q_reg ? (~acc_reg + 1'b1) : acc_reg;
        if (dz_pend_reg || !is_div_reg) begin
            fix_hi = dz_pend_reg ? acc_reg[2*WIDTH-1:WIDTH] : prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = dz_pend_reg ? acc_reg[WIDTH-1:0]       : prod_fix[WIDTH-1:0];
        end else begin
            fix_hi = neg_r_reg ? (~acc_reg[2*WIDTH-1:WIDTH] + 1'b1) : acc_reg[2*WIDTH-1:WIDTH];
            fix_lo = neg_q_reg ? (~acc_reg[WIDTH-1:0] + 1'b1)       : acc_reg[WIDTH-1:0];
        end

        last_iter = (cnt_reg == CNT_W'(WIDTH - 1));
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if ((is_div || is_divu) && (b == '0)) begin
                    state_next = S_FIX;
                end else if (is_mult || is_multu) begin
                    state_next = S_MUL;
                end else if (is_div || is_divu) begin
                    state_next = S_DIV;
                end
            end
            S_MUL:   if (last_iter) state_next = S_FIX;
            S_DIV:   if (last_iter) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- datapath / architectural state ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= '0;
            acc_reg     <= '0;
            opnd_reg    <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            is_div_reg  <= 1'b0;
            dz_pend_reg <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            dz_reg      <= 1'b0;
        end else begin
            busy_reg <= (state_next != S_IDLE);
            done_reg <= (state_reg == S_FIX);
            case (state_reg)
                S_IDLE: begin
                    if (is_op) begin
                        cnt_reg     <= '0;
                        dz_reg      <= 1'b0;
                        neg_q_reg   <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r_reg   <= op_signed && a[WIDTH-1];
                        is_div_reg  <= is_div || is_divu;
                        dz_pend_reg <= (is_div || is_divu) && (b == '0);
                        if ((is_div || is_divu) && (b == '0)) begin
                            acc_reg  <= {a, {WIDTH{1'b1}}};
                            opnd_reg <= '0;
                        end else if (is_mult || is_multu) begin
                            acc_reg  <= {{WIDTH{1'b0}}, b_mag};
                            opnd_reg <= a_mag;
                        end else begin
                            acc_reg  <= {{WIDTH{1'b0}}, a_mag};
                            opnd_reg <= b_mag;
                        end
                    end
                    if (is_mthi) hi_reg <= a;
                    if (is_mtlo) lo_reg <= a;
                end
                S_MUL: begin
                    acc_reg <= mul_acc_next;
                    cnt_reg <= cnt_reg + 1'b1;
                end
                S_DIV: begin
                    acc_reg <= div_acc_next;
                    cnt_reg <= cnt_reg + 1'b1;
                end
                S_FIX: begin
                    hi_reg <= fix_hi;
                    lo_reg <= fix_lo;
                    if (dz_pend_reg) dz_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed vectors, scoreboard checking of the
// HI/LO/div_by_zero values presented with each done pulse, plus inline checks
// of busy length, stall, result reads and reset behaviour.
module tb_muldiv_unit;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a, b;
    logic [31:0] result, hi, lo;
    logic        busy, stall, done, div_by_zero;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .aluop(aluop), .funct(funct),
        .a(a), .b(b), .result(result), .hi(hi), .lo(lo), .busy(busy),
        .stall(stall), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 (no pending op)");
            end else begin
                mon_e = sb.pop_front();
                $display("txn %s hi=%h lo=%h dz=%0b", mon_e.name, hi, lo, div_by_zero);
                chk({mon_e.name, ".hi"}, hi, mon_e.hi);
                chk({mon_e.name, ".lo"}, lo, mon_e.lo);
                chk({mon_e.name, ".dz"}, {31'b0, div_by_zero}, {31'b0, mon_e.dz});
            end
        end
    end

    task automatic drive(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1; aluop = 2'b10; funct = f; a = av; b = bv;
    endtask

    task automatic idle_in();
        start = 1'b0; aluop = 2'b00; funct = 6'd0; a = '0; b = '0;
    endtask

    // Wait (bounded) for busy to fall; returns cycles counted after accept.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
    endtask

    task automatic run_op(input string name, input logic [5:0] f,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz, input int ebusy);
        int cnt;
        @(negedge clk);
        sb.push_back('{name, ehi, elo, edz});
        drive(f, av, bv);
        @(posedge clk); #1;
        idle_in();
        chk({name, ".dz_clr_on_accept"}, {31'b0, div_by_zero}, 32'd0);
        wait_idle(cnt);
        chk({name, ".busy_cycles"}, cnt, ebusy);
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.hi", hi, 32'd0);
        chk("rst.lo", lo, 32'd0);
        chk("rst.busy", {31'b0, busy}, 32'd0);
        chk("rst.done", {31'b0, done}, 32'd0);
        chk("rst.dz", {31'b0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mult_m1x2",   F_MULT,  32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33);
        run_op("multu_m1x2",  F_MULTU, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33);
        run_op("div_m7d2",    F_DIV,   32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
        run_op("divu_100d7",  F_DIVU,  32'd100,      32'd7, 32'd2,        32'd14,       1'b0, 33);
        run_op("div_minm1",   F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 33);
        run_op("div_7dm2",    F_DIV,   32'd7,        32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 33);
        run_op("divu_100d0",  F_DIVU,  32'd100,      32'd0, 32'd100,      32'hFFFFFFFF, 1'b1, 1);
        chk("dz.sticky_after_fix", {31'b0, div_by_zero}, 32'd1);
        run_op("mult_3xm5",   F_MULT,  32'd3,        32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33);

        // Instructions presented during an in-flight MULT must stall, not issue.
        @(negedge clk);
        sb.push_back('{"mult_inflight", 32'h00000001, 32'h23456780, 1'b0});
        drive(F_MULT, 32'h12345678, 32'h10);
        @(posedge clk); #1;
        idle_in();
        repeat (3) @(posedge clk);
        #1;
        drive(F_MFLO, 32'd0, 32'd0);
        #1 chk("inflight.stall_mflo", {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        drive(F_DIVU, 32'd10, 32'd0);
        #1 chk("inflight.stall_div", {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        start = 1'b1; aluop = 2'b00; funct = F_MULT;
        #1 chk("inflight.nostall_nonr", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        idle_in();
        wait_idle(cnt);
        chk("inflight.busy_bounded", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("inflight.not_accepted_busy", {31'b0, busy}, 32'd0);
        chk("inflight.not_accepted_dz", {31'b0, div_by_zero}, 32'd0);
        drive(F_MFLO, 32'd0, 32'd0);
        #1 chk("mflo_after_mult", result, 32'h23456780);
        drive(F_MFHI, 32'd0, 32'd0);
        #1 chk("mfhi_after_mult", result, 32'h00000001);
        drive(6'b100000, 32'd5, 32'd5);
        #1 chk("invalid_funct.result", result, 32'd0);
        @(posedge clk); #1;
        chk("invalid_funct.busy", {31'b0, busy}, 32'd0);
        idle_in();

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        drive(F_DIV, 32'd1000, 32'd3);
        @(posedge clk); #1;
        idle_in();
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst.hi", hi, 32'd0);
        chk("midrst.lo", lo, 32'd0);
        chk("midrst.busy", {31'b0, busy}, 32'd0);
        chk("midrst.done", {31'b0, done}, 32'd0);
        chk("midrst.dz", {31'b0, div_by_zero}, 32'd0);
        chk("midrst.result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // MTHI/MTLO then immediate read-back.
        @(negedge clk);
        drive(F_MTHI, 32'h1234, 32'd0);
        @(posedge clk); #1;
        chk("mthi.busy", {31'b0, busy}, 32'd0);
        drive(F_MFHI, 32'd0, 32'd0);
        #1 chk("mthi_mfhi.result", result, 32'h1234);
        @(negedge clk);
        drive(F_MTLO, 32'h5678, 32'd0);
        @(posedge clk); #1;
        drive(F_MFLO, 32'd0, 32'd0);
        #1 chk("mtlo_mflo.result", result, 32'h5678);
        @(posedge clk); #1;
        idle_in();

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the Execute stage, with architectural HI/LO registers. It decodes MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO from the ID/EX funct field when the main decoder signals R-type. Multiplies run as one-bit-per-cycle shift-add; divides run as restoring division. While an operation is in flight the unit raises a stall, so the hazard logic can freeze the front of the pipeline.

## Interface
- WIDTH, 32, operand width; HI/LO are WIDTH bits each; iteration count equals WIDTH.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  ID/EX entry valid this cycle.
- aluop  in  2  from ID/EX; only 2'b10 (R-type) enables decode.
- funct  in  6  MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
- a  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- b  in  WIDTH  rt operand: multiplier or divisor.
- result  out  WIDTH  combinational: HI for MFHI, LO for MFLO, otherwise 0.
- hi, lo  out  WIDTH  architectural HI/LO registers.
- busy  out  1  registered; high while an operation is in flight.
- stall  out  1  combinational request to freeze IF/ID/EX.
- done  out  1  registered one-cycle pulse when HI/LO are written by an operation.
- div_by_zero  out  1  sticky flag; cleared when the next MULT/DIV is accepted.

## Operation
- Decode is valid when start=1, aluop=2'b10 and funct is one of the eight codes above. Any other input produces no state change and result=0.
- FSM states:
  - IDLE:
    - A valid MULT/MULTU/DIV/DIVU is accepted. The unit latches operand magnitudes (absolute values for the signed forms, raw values for the unsigned forms), the sign bits and the op type. Counter is cleared and div_by_zero is cleared. Next state is MUL or DIV.
    - DIV/DIVU with b==0 goes instead to FIX with the dz condition.
    - MTHI/MTLO writes a into hi/lo at the edge. FSM stays in IDLE.
  - MUL: one shift-add step per cycle on a 2*WIDTH accumulator. Counter increments. Moves to FIX when counter==WIDTH-1.
  - DIV: one restoring step per cycle (shift the remainder, trial-subtract the divisor, set the quotient bit). Moves to FIX when counter==WIDTH-1.
  - FIX: applies the sign correction and writes HI/LO. done=1 on the following cycle. Returns to IDLE.
- Sign rules:
  - MULT: negate the 2*WIDTH product when a[31]^b[31].
  - DIV: quotient sign = a[31]^b[31]; remainder sign = a[31].
  - Results are truncated to WIDTH bits. 0x80000000 / -1 gives lo=0x80000000, hi=0.
- Result placement:
  - Multiply: hi = product[63:32], lo = product[31:0].
  - Divide: lo = quotient, hi = remainder.
  - Divide by zero: lo = 0xFFFFFFFF, hi = a, div_by_zero=1.
- stall = busy & start & aluop==2'b10 & (funct is any of the eight codes). Any muldiv-class instruction arriving while busy is held, not accepted.
- While busy, any valid start is ignored. Non-muldiv instructions do not stall.
- MFHI/MFLO when not busy reads the current hi/lo combinationally. An MTHI/MTLO followed by MFHI/MFLO on the next cycle returns the new value.

## Timing
- Reset (asynchronous, any time including mid-operation): FSM=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, div_by_zero=0. Any in-flight operation is discarded.
- Accept at edge E0. busy=1 from after E0 until after E_WIDTH+1, i.e. 33 cycles for WIDTH=32.
- hi/lo update at E_WIDTH+1. In the cycle after it, done=1 and busy=0. A new operation may be accepted at that same edge.
- Divide by zero: accept at E0, FIX at E1. hi/lo, done and div_by_zero are valid after E1. busy is high for exactly one cycle.
- MTHI/MTLO: hi/lo are valid after one edge; busy stays 0.
- Back-to-back: an operation presented while done=1 is accepted, and busy rises after that edge.

## Test plan
- MULT a=0xFFFFFFFF, b=0x00000002:
  - busy high for 33 cycles, then done pulse.
  - hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU with the same operands: hi=0x00000001, lo=0xFFFFFFFE after 33 cycles.
- DIV a=0xFFFFFFF9 (-7), b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7: lo=14, hi=2.
- DIVU a=100, b=0:
  - after 1 cycle, done=1, lo=0xFFFFFFFF, hi=100, div_by_zero=1.
  - a following MULT clears div_by_zero on accept.
- During an in-flight MULT, present MFLO then DIV:
  - stall=1 on each, neither is accepted.
  - after done, MFLO returns the MULT low word.
- Assert rst at iteration 10 of a DIV:
  - all outputs go to 0 immediately.
  - MTHI a=0x1234 then MFHI on the next cycle gives result=0x1234.
